// File: rtl/fb_pkg.sv
// Types and defaults shared by the frame-buffer reader and the pattern writer.
package fb_pkg;

  localparam int unsigned HDISP_DFLT      = 800;
  localparam int unsigned VDISP_DFLT      = 480;
  localparam int unsigned BYTES_PER_PIXEL = 4;
  localparam int unsigned RGB_W           = 24;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [RGB_W-1:0] rgb;
  } pixel_t;

  localparam int unsigned PIXEL_W = $bits(pixel_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle, 32-bit address and data.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, ack, dat_sm,
    output cyc, stb, adr, we, sel, cti, bte, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, adr, we, sel, cti, bte, dat_ms,
    output ack, dat_sm
  );

endinterface

// File: rtl/fb_fifo.sv
// Single-clock show-ahead FIFO; the head word is readable while not empty.
module fb_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers and occupancy; a simultaneous push and pop leaves the count as is.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fb_reader.sv
// Wishbone master streaming the frame buffer in raster order onto a valid/ready
// pixel port; requests are throttled by FIFO room and a one-clock fairness gap.
module fb_reader
  import fb_pkg::*;
#(
  parameter int unsigned HDISP      = HDISP_DFLT,
  parameter int unsigned VDISP      = VDISP_DFLT,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned BURST      = 64
) (
  wshb_if.master           wshb_ifm,
  output logic             pix_valid,
  output logic [RGB_W-1:0] pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  input  logic             pix_ready
);

  localparam int unsigned ADR_W  = $clog2(HDISP * VDISP * BYTES_PER_PIXEL);
  localparam int unsigned PIX_W  = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned LINE_W = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BCNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]  SPACE_MAX = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [ADR_W-1:0]  ADR_STEP  = ADR_W'(BYTES_PER_PIXEL);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(HDISP - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(VDISP - 1);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST - 1);

  logic clk;
  logic rst;

  rd_state_e         state_q, state_d;
  logic              cyc_q, cyc_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [BCNT_W-1:0] burst_q, burst_d;

  logic               ack_req;
  logic               last_pix;
  logic               last_line;
  logic               push;
  logic               pop;
  pixel_t             push_pix;
  pixel_t             head;
  logic [PIXEL_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   fifo_count_nxt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               space;
  logic               room_after;

  assign clk = wshb_ifm.clk;
  assign rst = wshb_ifm.rst;

  assign ack_req   = wshb_ifm.ack && (state_q == REQ);
  assign last_pix  = (pixel_q == PIX_LAST);
  assign last_line = (line_q == LINE_LAST);
  assign push      = ack_req;
  assign pop       = pix_valid && pix_ready;

  always_comb begin
    push_pix     = '0;
    push_pix.sof = (pixel_q == '0) && (line_q == '0);
    push_pix.eol = last_pix;
    push_pix.rgb = wshb_ifm.dat_sm[RGB_W-1:0];
  end

  // Occupancy as it will be after this clock's push and pop.
  always_comb begin
    fifo_count_nxt = fifo_count;
    if (push && !pop)      fifo_count_nxt = fifo_count + CNT_W'(1);
    else if (!push && pop) fifo_count_nxt = fifo_count - CNT_W'(1);
  end

  // Keep one slot free for the word that may still be in flight.
  assign space      = (fifo_count <= SPACE_MAX) && !fifo_full;
  assign room_after = (fifo_count_nxt <= SPACE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (space) state_d = REQ;
      REQ: begin
        if (ack_req && ((burst_q == BURST_LAST) || !room_after)) state_d = GAP;
      end
      GAP:     state_d = space ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d = 1'b0;
    if (state_d == REQ) cyc_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_q <= '0;
      line_q  <= '0;
      adr_q   <= '0;
      burst_q <= '0;
    end else begin
      pixel_q <= pixel_d;
      line_q  <= line_d;
      adr_q   <= adr_d;
      burst_q <= burst_d;
    end
  end

  // Raster position and running byte address advance once per accepted read.
  always_comb begin
    pixel_d = pixel_q;
    line_d  = line_q;
    adr_d   = adr_q;
    burst_d = burst_q;
    if (ack_req) begin
      adr_d   = adr_q + ADR_STEP;
      burst_d = burst_q + BCNT_W'(1);
      if (last_pix) begin
        pixel_d = '0;
        if (last_line) begin
          line_d = '0;
          adr_d  = '0;
        end else begin
          line_d = line_q + LINE_W'(1);
        end
      end else begin
        pixel_d = pixel_q + PIX_W'(1);
      end
    end
    if ((state_q == REQ) && (state_d != REQ)) burst_d = '0;
  end

  fb_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (push_pix),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head      = pixel_t'(fifo_rdata);
  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? head.rgb : '0;
  assign pix_sof   = pix_valid && head.sof;
  assign pix_eol   = pix_valid && head.eol;

  assign wshb_ifm.cyc    = cyc_q;
  assign wshb_ifm.stb    = cyc_q;
  assign wshb_ifm.adr    = 32'(adr_q);
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.dat_ms = 32'h0;

endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: memory-model slave with optional wait states and a
// raster-order scoreboard driven from pixel index, not from DUT internals.
module tb_fb_reader;
  import fb_pkg::*;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int unsigned D    = 8;
  localparam int unsigned B    = 64;
  localparam int unsigned NPIX = H * V;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_if wb_if (.clk(clk), .rst(rst));

  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_ready = 1'b0;

  fb_reader #(
    .HDISP      (H),
    .VDISP      (V),
    .FIFO_DEPTH (D),
    .BURST      (B)
  ) dut (
    .wshb_ifm  (wb_if),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_ready (pix_ready)
  );

  int unsigned n_vec     = 0;
  int unsigned n_err     = 0;
  int unsigned waits     = 0;
  logic        spur      = 1'b0;
  logic [3:0]  wcnt;
  int unsigned m_idx     = 0;
  int unsigned ack_total = 0;
  int unsigned pop_total = 0;
  pixel_t      exp_q[$];
  pixel_t      mon_e;
  pixel_t      mon_got;
  logic [31:0] mon_w;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    x = a * 32'h9E3779B1;
    return x ^ {x[15:0], x[31:16]} ^ 32'h00C0FFEE;
  endfunction

  // Slave: ack after 'waits' stalled cycles; spur forces ack regardless of stb.
  assign wb_if.dat_sm = mem_word(wb_if.adr);
  assign wb_if.ack    = (wb_if.cyc && wb_if.stb && (32'(wcnt) == waits)) || spur;

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= '0;
    else if (wb_if.cyc && wb_if.stb && (32'(wcnt) != waits)) wcnt <= wcnt + 4'd1;
    else wcnt <= '0;
  end

  // Reference model: each accepted read is the next raster pixel of the frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_if.cyc && wb_if.stb && wb_if.ack) begin
        n_vec++;
        if (wb_if.adr !== 32'(m_idx * BYTES_PER_PIXEL)) begin
          n_err++;
          $display("FAIL adr: got %0h, expected %0h", wb_if.adr, m_idx * BYTES_PER_PIXEL);
        end
        mon_w     = mem_word(32'(m_idx * BYTES_PER_PIXEL));
        mon_e.sof = (m_idx == 0);
        mon_e.eol = ((m_idx % H) == (H - 1));
        mon_e.rgb = mon_w[23:0];
        exp_q.push_back(mon_e);
        m_idx = (m_idx + 1) % NPIX;
        ack_total++;
      end
      if (pix_valid && pix_ready) begin
        n_vec++;
        mon_got = {pix_sof, pix_eol, pix_data};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pix_stream: got %0h, expected no pixel", mon_got);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_got !== mon_e) begin
            n_err++;
            $display("FAIL pix_stream: got %0h, expected %0h", mon_got, mon_e);
          end
        end
        pop_total++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned guard;
    logic [31:0] w0;
    pix_ready = 1'b1;
    waits     = 0;
    spur      = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({wb_if.cyc, wb_if.stb} !== 2'b00) begin
      n_err++; $display("FAIL rst_cyc_stb: got %b, expected 00", {wb_if.cyc, wb_if.stb});
    end
    n_vec++;
    if (wb_if.adr !== 32'h0) begin
      n_err++; $display("FAIL rst_adr: got %0h, expected 0", wb_if.adr);
    end
    n_vec++;
    if (pix_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b, expected 0", pix_valid);
    end
    n_vec++;
    if ({pix_sof, pix_eol, pix_data} !== 26'h0) begin
      n_err++; $display("FAIL rst_pix: got %0h, expected 0", {pix_sof, pix_eol, pix_data});
    end
    exp_q.delete();
    m_idx = 0;
    rst   = 1'b0;
    #1;
    n_vec++;
    if (wb_if.cyc !== 1'b0) begin
      n_err++; $display("FAIL release_idle: got cyc=%b, expected 0", wb_if.cyc);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({wb_if.cyc, wb_if.stb} !== 2'b11) begin
      n_err++; $display("FAIL first_req: got %b, expected 11", {wb_if.cyc, wb_if.stb});
    end
    guard = 0;
    while (!pix_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    w0 = mem_word(32'h0);
    n_vec++;
    if ({pix_valid, pix_sof, pix_eol, pix_data} !== {1'b1, 1'b1, 1'b0, w0[23:0]}) begin
      n_err++;
      $display("FAIL first_pixel: got %0h, expected %0h",
               {pix_valid, pix_sof, pix_eol, pix_data}, {1'b1, 1'b1, 1'b0, w0[23:0]});
    end
  endtask

  task automatic test_free_run();
    int unsigned run_hi, run_lo, bursts;
    logic prev;
    pix_ready = 1'b1;
    waits     = 0;
    spur      = 1'b0;
    do_reset();
    run_hi = 0;
    run_lo = 0;
    bursts = 0;
    prev   = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (wb_if.cyc) begin
        if (!prev && bursts > 0) begin
          n_vec++;
          if (run_lo != 1) begin
            n_err++; $display("FAIL gap_len: got %0d, expected 1", run_lo);
          end
        end
        run_lo = 0;
        if (wb_if.ack) run_hi++;
      end else begin
        if (prev) begin
          n_vec++;
          if (run_hi != B) begin
            n_err++; $display("FAIL burst_len: got %0d, expected %0d", run_hi, B);
          end
          bursts++;
        end
        run_hi = 0;
        run_lo++;
      end
      prev = wb_if.cyc;
    end
    n_vec++;
    if (bursts < 4) begin
      n_err++; $display("FAIL burst_count: got %0d, expected >= 4", bursts);
    end
  endtask

  task automatic test_frame_wrap();
    int unsigned k;
    waits = 0;
    spur  = 1'b0;
    do_reset();
    k = 0;
    for (int c = 0; c < 400 && k < 70; c++) begin
      @(posedge clk);
      #1;
      pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        n_vec++;
        if (pix_eol !== ((k % H) == (H - 1))) begin
          n_err++; $display("FAIL eol: pixel %0d got %b, expected %b", k, pix_eol, (k % H) == (H - 1));
        end
        n_vec++;
        if (pix_sof !== ((k % NPIX) == 0)) begin
          n_err++; $display("FAIL sof: pixel %0d got %b, expected %b", k, pix_sof, (k % NPIX) == 0);
        end
        k++;
      end
    end
    n_vec++;
    if (k < 70) begin
      n_err++; $display("FAIL wrap_timeout: got %0d pixels, expected 70", k);
    end
  endtask

  task automatic test_backpressure();
    int unsigned a0, p0;
    pix_ready = 1'b0;
    waits     = 0;
    spur      = 1'b0;
    do_reset();
    a0 = ack_total;
    repeat (40) @(negedge clk);
    n_vec++;
    if (ack_total - a0 != D - 1) begin
      n_err++; $display("FAIL bp_reads: got %0d, expected %0d", ack_total - a0, D - 1);
    end
    n_vec++;
    if (wb_if.cyc !== 1'b0) begin
      n_err++; $display("FAIL bp_idle: got cyc=%b, expected 0", wb_if.cyc);
    end
    n_vec++;
    if (pix_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_valid: got %b, expected 1", pix_valid);
    end
    @(posedge clk);
    #1;
    spur = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (wb_if.adr !== 32'((D - 1) * BYTES_PER_PIXEL)) begin
      n_err++; $display("FAIL spur_adr: got %0h, expected %0h", wb_if.adr, (D - 1) * BYTES_PER_PIXEL);
    end
    n_vec++;
    if (wb_if.cyc !== 1'b0) begin
      n_err++; $display("FAIL spur_cyc: got %b, expected 0", wb_if.cyc);
    end
    p0 = pop_total;
    @(posedge clk);
    #1;
    pix_ready = 1'b1;
    repeat (150) @(negedge clk);
    @(posedge clk);
    #1;
    spur = 1'b0;
    n_vec++;
    if (pop_total - p0 < 100) begin
      n_err++; $display("FAIL bp_resume: got %0d pops, expected >= 100", pop_total - p0);
    end
  endtask

  task automatic test_wait_states();
    int unsigned p0;
    waits     = 3;
    spur      = 1'b0;
    pix_ready = 1'b0;
    do_reset();
    p0 = pop_total;
    for (int c = 0; c < 4000 && (pop_total - p0) < 2 * NPIX + 8; c++) begin
      @(posedge clk);
      #1;
      pix_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    n_vec++;
    if (pop_total - p0 < 2 * NPIX + 8) begin
      n_err++; $display("FAIL ws_timeout: got %0d pops, expected %0d", pop_total - p0, 2 * NPIX + 8);
    end
  endtask

  task automatic test_reset_mid_burst();
    int unsigned a0, guard;
    waits     = 3;
    spur      = 1'b0;
    pix_ready = 1'b0;
    do_reset();
    a0    = ack_total;
    guard = 0;
    while (guard < 200 && !(ack_total >= a0 + 3 && wb_if.cyc && wb_if.stb && !wb_if.ack)) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if ({pix_valid, wb_if.stb, wb_if.ack} !== 3'b110) begin
      n_err++; $display("FAIL mid_setup: got valid/stb/ack=%b, expected 110",
                        {pix_valid, wb_if.stb, wb_if.ack});
    end
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    #1;
    n_vec++;
    if ({wb_if.cyc, wb_if.stb, pix_valid} !== 3'b000) begin
      n_err++; $display("FAIL mid_async: got %b, expected 000", {wb_if.cyc, wb_if.stb, pix_valid});
    end
    @(posedge clk);
    #1;
    pix_ready = 1'b1;
    rst       = 1'b0;
    guard     = 0;
    while (guard < 50 && !(wb_if.cyc && wb_if.stb && wb_if.ack)) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if ({wb_if.ack, wb_if.adr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL mid_first_adr: got ack=%b adr=%0h, expected ack=1 adr=0",
                        wb_if.ack, wb_if.adr);
    end
    guard = 0;
    while (guard < 50 && !pix_valid) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if ({pix_valid, pix_sof} !== 2'b11) begin
      n_err++; $display("FAIL mid_sof: got valid/sof=%b, expected 11", {pix_valid, pix_sof});
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_frame_wrap();
    test_backpressure();
    test_wait_states();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_reader.md
# fb_reader

Wishbone master that reads the frame buffer in raster order and delivers pixels on a valid/ready stream to the display-timing side. It is the read-side counterpart of the test-pattern writer: same address map (32-bit word per pixel, byte address = (HDISP·line + pixel)·4) and same bus interface. A small internal FIFO decouples bus latency from display back-pressure. Bus requests are throttled by FIFO occupancy and by a fairness gap.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- FIFO_DEPTH, 256, pixel FIFO depth; power of two, ≥ 4
- BURST, 64, reads per cycle before cyc is released for one clock
- wshb_ifm.clk  in  1  bus and block clock (single clock domain)
- wshb_ifm.rst  in  1  asynchronous, active-high reset
- wshb_ifm  wshb_if.master  —  Wishbone master: drives cyc, stb, adr[31:0], we, sel, cti, bte, dat_ms; samples ack, dat_sm[31:0]
- pix_valid  out  1  FIFO head holds a pixel
- pix_data  out  24  RGB888 = dat_sm[23:0]
- pix_sof  out  1  head pixel is (line 0, pixel 0)
- pix_eol  out  1  head pixel is pixel HDISP-1
- pix_ready  in  1  consumer accepts head when pix_valid=1

## Operation
- Constant outputs: we=0, sel=4'b1111, cti=3'b000, bte=2'b00, dat_ms=0.
- Classic single reads: stb held high until ack; one ack = one pixel; at most one outstanding read.
- Position counters pixel_cpt (0..HDISP-1), line_cpt (0..VDISP-1) advance on ack; pixel wraps to 0 and increments line; line wraps at VDISP-1 → 0 (frame restarts at address 0, no idle gap).
- adr registered, = (HDISP·line_cpt + pixel_cpt)·4 for the current request; maintained as a running byte counter (+4 per ack, 0 after last pixel of frame), no multiplier. Width $clog2(HDISP·VDISP·4), zero-extended to 32.
- On ack: push {sof, eol, dat_sm[23:0]} into FIFO; sof/eol computed from counters before increment.
- Space condition: fifo_count ≤ FIFO_DEPTH-2 (guarantees room for the in-flight word).
- FSM:
  - IDLE: cyc=stb=0; → REQ when space.
  - REQ: cyc=stb=1; on ack: if burst_cnt==BURST-1 or fifo_count (after this push/pop) > FIFO_DEPTH-2 → GAP, else stay REQ. burst_cnt increments on ack, clears on leaving REQ.
  - GAP: cyc=stb=0 exactly one cycle; → REQ if space, else IDLE.
- FIFO: show-ahead; pix_valid = !empty; pop on pix_valid & pix_ready. Simultaneous push and pop: count unchanged, both take effect. Push never occurs when full (gated by space condition); pop on empty impossible (ready ignored when !valid).
- ack while not in REQ is ignored (no push, no counter change).

## Timing
- Reset values: cyc=0, stb=0, adr=0, FSM=IDLE, counters 0, burst_cnt 0, FIFO empty, pix_valid=0, pix_data/sof/eol=0.
- First request: cyc=stb=1 in the first cycle after reset release (IDLE→REQ takes one clock).
- adr updates the clock after ack; next stb in REQ carries new adr in that same cycle.
- Ack at edge N → pixel visible on pix_* after edge N (1-cycle push latency).
- Steady state with zero-wait-state slave and pix_ready=1: BURST pixels per BURST+1 clocks.
- Reset mid-burst: all state returns to reset values immediately; FIFO contents discarded; next frame starts at address 0 with sof.

## Structure
- Package fb_pkg: pixel record type {sof, eol, rgb[23:0]}, FSM enum {IDLE, REQ, GAP}, shared HDISP/VDISP defaults and BYTES_PER_PIXEL=4 (shared with the pattern writer).
- Sub-module fb_fifo: single-clock show-ahead FIFO, parameters WIDTH, DEPTH, outputs count/empty/full.
- fb_reader holds FSM, counters, address generator.

## Test plan
- Reset then free run, zero-wait slave, pix_ready=1: adr sequence 0,4,8,…; cyc low one cycle after every 64 acks; first pixel has pix_sof=1.
- HDISP=8, VDISP=4: pix_eol on pixels 7,15,…; after pixel 31 adr returns to 0 and next pixel has pix_sof=1.
- pix_ready=0, FIFO_DEPTH=8: exactly 7 pixels read (count ≤ 6 before request), then cyc=0 until ready reasserts; no overflow, no lost data.
- Slave with 3 wait states and random pix_ready: received pix_data equals memory model contents in raster order across two frames.
- Assert rst mid-burst (stb high, ack pending): cyc/stb/pix_valid go 0 asynchronously; after release first adr=0 with sof.
- Spurious ack during GAP/IDLE: no FIFO push, counters and adr unchanged.
